// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative signed/unsigned multiply and divide unit returning a {hi, lo} pair
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e               state_q, state_d;
    logic                 div_q, div_d;
    logic                 neg_q, neg_d;
    logic                 nega_q, nega_d;
    logic                 dz_q, dz_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sa, sb;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0]   mul_nxt, div_nxt, prod;
    logic [WIDTH-1:0]     quo, rem;

    // Signed ops work on magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign sa    = ~op[0] & opa[WIDTH-1];
    assign sb    = ~op[0] & opb[WIDTH-1];
    assign mag_a = sa ? -opa : opa;
    assign mag_b = sb ? -opb : opb;

    // acc holds {partial product, remaining multiplier bits}; one bit retired per step.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // acc holds {remainder, dividend bits shifting into quotient}; borrow means restore.
    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, m_q};
    assign div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = nega_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    assign ready    = state_q == IDLE;
    assign done     = state_q == DONE;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

    // Next-state and datapath update; cancel aborts CALC/FIX without touching results.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (start && !cancel) begin
                div_d  = op[1];
                neg_d  = sa ^ sb;
                nega_d = sa;
                cnt_d  = '0;
                m_d    = op[1] ? mag_b : mag_a;
                acc_d  = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                if (op[1] && opb == '0) begin
                    state_d = DONE;
                    hi_d    = opa;
                    lo_d    = '1;
                    dz_d    = 1'b1;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: if (cancel) begin
                state_d = IDLE;
            end else begin
                acc_d   = div_q ? div_nxt : mul_nxt;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(WIDTH - 1) ? FIX : CALC;
            end
            FIX: if (cancel) begin
                state_d = IDLE;
            end else begin
                hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quo : prod[WIDTH-1:0];
                dz_d    = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and model-checked vectors for ex_muldiv at WIDTH 32, 16 and 8
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        ready32, done32, dz32, ready16, done16, dz16, ready8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;
    logic [7:0]  hi8, lo8;
    int          checks = 0;
    int          errors = 0;
    int          lat32, lat16, lat8;
    logic        seen;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .cancel(cancel), .ready(ready32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32));
    ex_muldiv #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .start(start), .op(op), .opa(opa[15:0]), .opb(opb[15:0]),
        .cancel(cancel), .ready(ready16), .done(done16), .hi(hi16), .lo(lo16), .div_zero(dz16));
    ex_muldiv #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .start(start), .op(op), .opa(opa[7:0]), .opb(opb[7:0]),
        .cancel(cancel), .ready(ready8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic at width w.
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] ai, input logic [31:0] bi,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        logic [63:0] mask, a, b, pu;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 1;
        a = {32'd0, ai} & mask;
        b = {32'd0, bi} & mask;
        sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        z = 1'b0;
        if (o[1] && b == 0) begin
            h = 32'(a);
            l = 32'(mask);
            z = 1'b1;
        end else if (!o[1]) begin
            pu = o[0] ? a * b : 64'(sa * sb);
            h = 32'((pu >> w) & mask);
            l = 32'(pu & mask);
        end else begin
            q = o[0] ? longint'(a / b) : sa / sb;
            r = o[0] ? longint'(a % b) : sa % sb;
            h = 32'(64'(r) & mask);
            l = 32'(64'(q) & mask);
        end
    endfunction

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; opa = $urandom; opb = $urandom;
        lat32 = 0; lat16 = 0; lat8 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done8 && lat8 == 0) lat8 = c;
            if (done16 && lat16 == 0) lat16 = c;
            if (done32) begin
                lat32 = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80;
            4: return 32'h8000;
            5: return 32'h80000000;
            6: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, eh, el;
        logic [1:0] o;
        logic ez;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ready32, 1);
        check("rst_done", done32, 0);
        check("rst_hi", hi32, 0);
        check("rst_lo", lo32, 0);
        check("rst_dz", dz32, 0);

        run(2'b00, 32'hFFFFFFFD, 32'd5);
        check("mult_lat", lat32, 34);
        check("mult_hi", hi32, 32'hFFFFFFFF);
        check("mult_lo", lo32, 32'hFFFFFFF1);
        @(negedge clk);
        check("mult_ready_after", ready32, 1);
        run(2'b01, 32'hFFFFFFFD, 32'd5);
        check("multu_hi", hi32, 32'h4);
        check("multu_lo", lo32, 32'hFFFFFFF1);
        run(2'b11, 32'd100, 32'd7);
        check("divu_lo", lo32, 14);
        check("divu_hi", hi32, 2);
        check("divu_dz", dz32, 0);
        run(2'b10, 32'hFFFFFFF9, 32'd2);
        check("div_neg_lo", lo32, 32'hFFFFFFFD);
        check("div_neg_hi", hi32, 32'hFFFFFFFF);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo", lo32, 32'h80000000);
        check("div_ovf_hi", hi32, 0);
        run(2'b10, 32'h80000000, 32'd1);
        check("div_min1_lo", lo32, 32'h80000000);
        check("div_min1_hi", hi32, 0);
        run(2'b11, 32'h1234, 32'd0);
        check("dz_lat", lat32, 1);
        check("dz_hi", hi32, 32'h1234);
        check("dz_lo", lo32, 32'hFFFFFFFF);
        check("dz_flag", dz32, 1);
        run(2'b00, 32'd2, 32'd3);
        check("dz_clear", dz32, 0);
        check("mult23_lo", lo32, 6);

        @(negedge clk);
        start = 1'b1; op = 2'b10; opa = 32'd1000; opb = 32'd3;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            seen |= done32;
            start = c == 4;
            cancel = c == 9;
        end
        cancel = 1'b0;
        start = 1'b0;
        seen |= done32;
        check("cancel_nodone", seen, 0);
        @(negedge clk);
        check("cancel_ready", ready32, 1);
        check("cancel_hold_hi", hi32, 0);
        check("cancel_hold_lo", lo32, 6);
        run(2'b01, 32'd3, 32'd4);
        check("after_cancel_lo", lo32, 12);
        check("after_cancel_hi", hi32, 0);
        check("after_cancel_lat", lat32, 34);

        @(negedge clk);
        start = 1'b1; op = 2'b11; opa = 32'd50; opb = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("calc_busy", ready32, 0);
        reset = 1'b1;
        #1;
        check("arst_ready", ready32, 1);
        check("arst_done", done32, 0);
        check("arst_lo", lo32, 0);
        check("arst_hi", hi32, 0);
        check("arst_dz", dz32, 0);
        @(negedge clk);
        reset = 1'b0;
        run(2'b11, 32'd9, 32'd3);
        check("post_rst_lo", lo32, 3);
        check("post_rst_hi", hi32, 0);

        for (int i = 0; i < 1000; i++) begin
            a = pick();
            b = pick();
            o = 2'($urandom_range(0, 3));
            run(o, a, b);
            model(32, o, a, b, eh, el, ez);
            check("r32_lat", lat32, ez ? 1 : 34);
            check("r32_hi", hi32, eh);
            check("r32_lo", lo32, el);
            check("r32_dz", dz32, ez);
            model(16, o, a, b, eh, el, ez);
            check("r16_lat", lat16, ez ? 1 : 18);
            check("r16_hi", hi16, eh);
            check("r16_lo", lo16, el);
            check("r16_dz", dz16, ez);
            model(8, o, a, b, eh, el, ez);
            check("r8_lat", lat8, ez ? 1 : 10);
            check("r8_hi", hi8, eh);
            check("r8_lo", lo8, el);
            check("r8_dz", dz8, ez);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit for the CPU execute stage. Computes signed and unsigned WIDTH×WIDTH multiply and WIDTH/WIDTH divide iteratively, and returns a {hi, lo} pair for the HI/LO register write path. The execute stage starts an operation with a one-cycle start strobe and stalls the pipeline until done. A cancel input lets a pipeline flush abort work in flight.

## Interface
Parameters:
- WIDTH, 32, operand and result width; any value ≥ 4.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only when ready=1.
- op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- opa  in  WIDTH  multiplicand / dividend.
- opb  in  WIDTH  multiplier / divisor.
- cancel  in  1  abort current operation (pipeline flush).
- ready  out  1  unit idle; a start is accepted this cycle.
- done  out  1  one-cycle pulse; hi/lo/div_zero valid.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.
- div_zero  out  1  last completed divide had opb==0.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. ready = (state==IDLE). done = (state==DONE).
- Accept edge: IDLE with start=1 and cancel=0.
  - Latch op.
  - Latch the operand magnitudes. For signed ops, a negative operand is replaced by its two's-complement magnitude, held as an unsigned WIDTH-bit value; the most-negative operand gives magnitude 2^(WIDTH-1).
  - Latch the result-sign flags.
  - Clear the iteration counter and go to CALC.
- Divide by zero (op[1]=1, opb==0) at the accept edge:
  - Go directly to DONE and register hi=opa (raw), lo=all ones, div_zero=1.
- CALC, multiply: shift-add, one multiplier bit per cycle, with a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC lasts exactly WIDTH edges; the counter is a $clog2(WIDTH+1)-bit up-counter. Then the FSM goes to FIX.
- FIX is one edge. It applies sign correction and registers hi/lo, with div_zero=0.
  - MULT: negate the 2·WIDTH product when opa and opb signs differ.
  - DIV: negate the quotient when the signs differ. The remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative / -1 (signed DIV): lo = most-negative value (wraps), hi = 0. No exception is raised.
  - Unsigned ops: no correction.
- DONE lasts one cycle, then the FSM returns to IDLE.
- hi, lo and div_zero hold their values until the next FIX or divide-by-zero update.
- start while ready=0 is ignored; there is no queuing.
- cancel=1 in CALC or FIX: return to IDLE at the next edge. hi, lo and div_zero are unchanged, and done is not asserted.
- cancel=1 in DONE: no effect; that cycle's done stands and the FSM returns to IDLE as normal.
- cancel=1 in IDLE: start is ignored.
- Operand inputs need not be held after the accept edge.

## Timing
- Reset values: state=IDLE, ready=1, done=0, hi=0, lo=0, div_zero=0, counter=0.
- Reset asserted mid-operation forces IDLE immediately; no done is produced.
- Normal latency, accept edge at k:
  - CALC iterations on edges k+1 … k+WIDTH.
  - FIX on edge k+WIDTH+1.
  - done high in the cycle between edges k+WIDTH+1 and k+WIDTH+2.
  - ready returns high after edge k+WIDTH+2.
  - Total for WIDTH=32: done in the 34th cycle after the accept cycle.
- Divide-by-zero latency: done high in the cycle immediately after the accept edge.
- Throughput: the next start is accepted in the cycle after done, because DONE→IDLE takes one edge.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Test plan
- MULT, WIDTH=32, opa=0xFFFFFFFD (-3), opb=5 → done exactly WIDTH+2 cycles after the accept cycle; hi=0xFFFFFFFF, lo=0xFFFFFFF1. The same operands with MULTU → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU, 100 / 7 → lo=14, hi=2, div_zero=0. DIV, -7 / 2 (0xFFFFFFF9 / 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIV, 0x80000000 / 1 → lo=0x80000000, hi=0.
- DIVU, opa=0x1234, opb=0 → done the cycle after accept; hi=0x1234, lo=0xFFFFFFFF, div_zero=1. A following MULT then clears div_zero to 0.
- Start a DIV, pulse start again on cycle 5 (ignored), assert cancel on cycle 10 → ready=1 on the next cycle, no done, hi/lo still hold the previous result. An immediate new MULTU 3×4 → lo=12, hi=0.
- Assert reset during CALC → all outputs return to their reset values asynchronously; after release, a DIVU 9/3 → lo=3, hi=0.
- Repeat the MULT, MULTU, DIV and DIVU cases with WIDTH=8 and WIDTH=16, comparing against a reference model on 1000 random operand pairs, including 0, 1, the most-negative value and all ones.
